// File: rtl/pcsp_pkg.sv
// Shared encodings for the PC/SP/memory stack unit: operation codes,
// sticky fault codes, sequencer states and small op-class helpers.
package pcsp_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_FETCH = 3'd1,
    OP_LOAD  = 3'd2,
    OP_STORE = 3'd3,
    OP_PUSH  = 3'd4,
    OP_POP   = 3'd5,
    OP_CALL  = 3'd6,
    OP_RET   = 3'd7
  } pcsp_op_e;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'd0,
    FAULT_OVERFLOW   = 2'd1,
    FAULT_UNDERFLOW  = 2'd2,
    FAULT_MISALIGNED = 2'd3
  } pcsp_fault_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_DONE = 2'd2
  } pcsp_state_e;

  // Operations that commit a memory write at the MEM edge.
  function automatic logic op_writes_mem(input pcsp_op_e o);
    return (o == OP_STORE) || (o == OP_PUSH) || (o == OP_CALL);
  endfunction

  // Operations whose response carries the word read at the MEM edge.
  function automatic logic op_returns_data(input pcsp_op_e o);
    return (o == OP_FETCH) || (o == OP_LOAD) || (o == OP_POP) || (o == OP_RET);
  endfunction

endpackage

// File: rtl/pcsp_ram.sv
// Single-port synchronous word RAM. A write and a read of the same word in
// one cycle returns the old contents (read-old-data). Contents are not reset.
module pcsp_ram #(
  parameter int DATA_W = 16,
  parameter int WORDS  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  // Write port and registered read port share one address.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/pcsp_stack_unit.sv
// PC / SP / IR / unified memory block. One operation at a time is sequenced
// IDLE -> MEM -> DONE. Handshake: an op is accepted on a rising edge where
// op_valid && op_ready; op_ready is high only in IDLE, op_valid is ignored
// elsewhere, and the op inputs need to be stable only at the accept edge.
// Completion is a one-cycle rsp_valid pulse registered at the DONE edge.
module pcsp_stack_unit
  import pcsp_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter int                MEM_WORDS   = 1024,
  parameter logic [ADDR_W-1:0] PC_RESET    = '0,
  parameter logic [ADDR_W-1:0] STACK_BASE  = 16'h0200,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = 16'h03FE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault,
  output logic [1:0]        fault_code,
  input  logic              fault_clear,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] sp_out
);

  localparam int                IDX_W = $clog2(MEM_WORDS);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(2);

  pcsp_state_e       state;
  pcsp_state_e       state_nxt;

  pcsp_op_e          op_in;
  pcsp_op_e          op_q;
  pcsp_fault_e       fault_in;
  pcsp_fault_e       fault_q;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] sp_q;
  logic [ADDR_W-1:0] ea;
  logic [ADDR_W-1:0] target_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] wdata_in;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] ram_rdata;
  logic [IDX_W-1:0]  idx_q;

  logic              accept;
  logic              ram_we;
  logic              committing;
  logic              unused_ea_bits;

  assign op_in    = pcsp_op_e'(op);
  assign op_ready = (state == ST_IDLE);
  assign accept   = op_valid && op_ready;

  // Only the word-index bits of the effective address reach the RAM; the
  // byte bit and the bits above the memory size are deliberately dropped so
  // addresses wrap.
  assign unused_ea_bits = ^{ea[ADDR_W-1:IDX_W+1], ea[0]};

  // Sequencer state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Sequencer next state: accept in IDLE, then MEM and DONE unconditionally.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = ST_MEM;
      ST_MEM:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Accept-time decode: effective address, fault check and write data.
  always_comb begin
    ea       = pc_q;
    fault_in = FAULT_NONE;
    wdata_in = op_wdata;
    unique case (op_in)
      OP_FETCH: ea = pc_q;
      OP_LOAD, OP_STORE: begin
        ea = op_addr;
        if (op_addr[0]) fault_in = FAULT_MISALIGNED;
      end
      OP_PUSH, OP_CALL: begin
        ea = sp_q;
        if (sp_q == STACK_LIMIT) fault_in = FAULT_OVERFLOW;
        if (op_in == OP_CALL) wdata_in = DATA_W'(pc_q + STEP);
      end
      OP_POP, OP_RET: begin
        ea = sp_q - STEP;
        if (sp_q == STACK_BASE) fault_in = FAULT_UNDERFLOW;
      end
      default: ea = pc_q;
    endcase
  end

  // Latch the accepted operation for the MEM and DONE steps.
  always_ff @(posedge clock) begin
    if (!reset) begin
      op_q     <= OP_NOP;
      fault_q  <= FAULT_NONE;
      idx_q    <= '0;
      target_q <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      op_q     <= op_in;
      fault_q  <= fault_in;
      idx_q    <= ea[IDX_W:1];
      target_q <= op_addr;
      wdata_q  <= wdata_in;
    end
  end

  // The write is gated by reset so an op abandoned at the MEM edge leaves
  // memory untouched.
  assign ram_we = (state == ST_MEM) && reset && (fault_q == FAULT_NONE) &&
                  op_writes_mem(op_q);

  pcsp_ram #(
    .DATA_W (DATA_W),
    .WORDS  (MEM_WORDS),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign committing = (state == ST_DONE) && (fault_q == FAULT_NONE);

  // Architectural commit of PC, SP and IR at the DONE edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q <= PC_RESET;
      sp_q <= STACK_BASE;
      ir_q <= '0;
    end else if (committing) begin
      unique case (op_q)
        OP_FETCH: begin
          ir_q <= ram_rdata;
          pc_q <= pc_q + STEP;
        end
        OP_PUSH: sp_q <= sp_q + STEP;
        OP_POP:  sp_q <= sp_q - STEP;
        OP_CALL: begin
          pc_q <= target_q;
          sp_q <= sp_q + STEP;
        end
        OP_RET: begin
          pc_q <= ADDR_W'(ram_rdata);
          sp_q <= sp_q - STEP;
        end
        default: ;
      endcase
    end
  end

  // Registered completion pulse with read data (zero when faulted or no read).
  always_ff @(posedge clock) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= (state == ST_DONE);
      rsp_fault <= (state == ST_DONE) && (fault_q != FAULT_NONE);
      rsp_data  <= (committing && op_returns_data(op_q)) ? ram_rdata : '0;
    end
  end

  // Sticky fault code: a newly completing fault wins over both the held
  // value and a simultaneous clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fault_code <= FAULT_NONE;
    end else if ((state == ST_DONE) && (fault_q != FAULT_NONE)) begin
      fault_code <= fault_q;
    end else if (fault_clear) begin
      fault_code <= FAULT_NONE;
    end
  end

  assign pc_out   = pc_q;
  assign sp_out   = sp_q;
  assign inst_out = ir_q;

endmodule

// File: tb/tb_pcsp_stack_unit.sv
// Directed bench for pcsp_stack_unit. Drivers push the hand-computed
// response into exp_q at accept; an independent monitor pops and compares
// whenever rsp_valid is seen.
module tb_pcsp_stack_unit;

  typedef struct packed {
    logic [15:0] data;
    logic        fault;
    logic [1:0]  code;
    logic [15:0] pc;
    logic [15:0] sp;
    logic [15:0] inst;
    logic [31:0] acc;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  localparam logic [2:0] NOP = 3'd0, FETCH = 3'd1, LOAD = 3'd2, STORE = 3'd3,
                         PUSH = 3'd4, POP = 3'd5, CALL = 3'd6, RET = 3'd7;

  // ---------------- clock / reset / DUT ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op = 3'd0;
  logic [15:0] op_addr = '0;
  logic [15:0] op_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_fault;
  logic [1:0]  fault_code;
  logic        fault_clear = 1'b0;
  logic [15:0] inst_out;
  logic [15:0] pc_out;
  logic [15:0] sp_out;

  logic [31:0] cyc = '0;
  int          n_tests = 0;
  int          n_fail = 0;

  logic [EXP_W-1:0] exp_q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  pcsp_stack_unit #(.PC_RESET(16'h000C)) dut (
    .clock       (clock),
    .reset       (reset),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op          (op),
    .op_addr     (op_addr),
    .op_wdata    (op_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_fault   (rsp_fault),
    .fault_code  (fault_code),
    .fault_clear (fault_clear),
    .inst_out    (inst_out),
    .pc_out      (pc_out),
    .sp_out      (sp_out)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Waits for ready, presents the op, returns just after the accept edge.
  task automatic do_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] w,
                       input logic [15:0] e_data, input logic e_fault, input logic [1:0] e_code,
                       input logic [15:0] e_pc, input logic [15:0] e_sp, input logic [15:0] e_inst,
                       input bit push_exp);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clock);
    while (!op_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!op_ready) begin
      check("ready_timeout", {31'd0, op_ready}, 32'd1);
      return;
    end
    op_valid = 1'b1;
    op       = o;
    op_addr  = a;
    op_wdata = w;
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    if (push_exp) begin
      e = '{data: e_data, fault: e_fault, code: e_code, pc: e_pc, sp: e_sp,
            inst: e_inst, acc: cyc};
      exp_q.push_back(EXP_W'(e));
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    @(negedge clock);
    while ((exp_q.size() != 0 || !op_ready) && k < 100) begin
      @(negedge clock);
      k++;
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    exp_t e;
    if (reset && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd0, 32'd1);
      end else begin
        e = exp_t'(exp_q.pop_front());
        check("rsp_data",   {16'd0, rsp_data},   {16'd0, e.data});
        check("rsp_fault",  {31'd0, rsp_fault},  {31'd0, e.fault});
        check("fault_code", {30'd0, fault_code}, {30'd0, e.code});
        check("pc_out",     {16'd0, pc_out},     {16'd0, e.pc});
        check("sp_out",     {16'd0, sp_out},     {16'd0, e.sp});
        check("inst_out",   {16'd0, inst_out},   {16'd0, e.inst});
        check("latency",    cyc - e.acc,         32'd2);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [8:0]  pat;
    logic [15:0] sp_m;
    exp_t        e;

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    check("rst_pc",    {16'd0, pc_out},     32'h000C);
    check("rst_sp",    {16'd0, sp_out},     32'h0200);
    check("rst_inst",  {16'd0, inst_out},   32'h0);
    check("rst_valid", {31'd0, rsp_valid},  32'h0);
    check("rst_data",  {16'd0, rsp_data},   32'h0);
    check("rst_fault", {31'd0, rsp_fault},  32'h0);
    check("rst_code",  {30'd0, fault_code}, 32'h0);
    check("rst_ready", {31'd0, op_ready},   32'h1);

    // Store / load round trip.
    do_op(STORE, 16'h0002, 16'd100, 16'd0,   0, 2'd0, 16'h000C, 16'h0200, 16'h0, 1);
    do_op(LOAD,  16'h0002, 16'd0,   16'd100, 0, 2'd0, 16'h000C, 16'h0200, 16'h0, 1);

    // Push / pop ordering.
    do_op(PUSH, 16'h0, 16'h1234, 16'h0,    0, 2'd0, 16'h000C, 16'h0202, 16'h0, 1);
    do_op(PUSH, 16'h0, 16'h5678, 16'h0,    0, 2'd0, 16'h000C, 16'h0204, 16'h0, 1);
    do_op(POP,  16'h0, 16'h0,    16'h5678, 0, 2'd0, 16'h000C, 16'h0202, 16'h0, 1);
    do_op(POP,  16'h0, 16'h0,    16'h1234, 0, 2'd0, 16'h000C, 16'h0200, 16'h0, 1);

    // Program words at the reset PC, two fetches, call and return.
    do_op(STORE, 16'h000C, 16'hA1B2, 16'h0, 0, 2'd0, 16'h000C, 16'h0200, 16'h0, 1);
    do_op(STORE, 16'h000E, 16'hC3D4, 16'h0, 0, 2'd0, 16'h000C, 16'h0200, 16'h0, 1);
    do_op(FETCH, 16'h0, 16'h0, 16'hA1B2, 0, 2'd0, 16'h000E, 16'h0200, 16'hA1B2, 1);
    do_op(FETCH, 16'h0, 16'h0, 16'hC3D4, 0, 2'd0, 16'h0010, 16'h0200, 16'hC3D4, 1);
    do_op(CALL,  16'h0100, 16'h0, 16'h0, 0, 2'd0, 16'h0100, 16'h0202, 16'hC3D4, 1);
    wait_done();
    check("call_ret_addr", {16'd0, dut.u_ram.mem[10'h100]}, 32'h0012);
    do_op(RET, 16'h0, 16'h0, 16'h0012, 0, 2'd0, 16'h0012, 16'h0200, 16'hC3D4, 1);

    // Underflow, then clear.
    do_op(POP, 16'h0, 16'h0, 16'h0, 1, 2'd2, 16'h0012, 16'h0200, 16'hC3D4, 1);
    wait_done();
    fault_clear = 1'b1;
    @(negedge clock);
    fault_clear = 1'b0;
    check("clear_after_underflow", {30'd0, fault_code}, 32'h0);

    // Sentinel at the top slot, fill to the limit, then overflow.
    do_op(STORE, 16'h03FE, 16'hDEAD, 16'h0, 0, 2'd0, 16'h0012, 16'h0200, 16'hC3D4, 1);
    sp_m = 16'h0200;
    for (int i = 0; i < 255; i++) begin
      sp_m = sp_m + 16'd2;
      do_op(PUSH, 16'h0, 16'(i), 16'h0, 0, 2'd0, 16'h0012, sp_m, 16'hC3D4, 1);
    end
    do_op(PUSH, 16'h0, 16'hBEEF, 16'h0, 1, 2'd1, 16'h0012, 16'h03FE, 16'hC3D4, 1);
    wait_done();
    check("overflow_no_write", {16'd0, dut.u_ram.mem[10'h1FF]}, 32'hDEAD);
    check("fill_last_word",    {16'd0, dut.u_ram.mem[10'h1FE]}, 32'h00FE);

    // Misaligned store while overflow is held; clear raised in the DONE
    // cycle must lose to the new fault, then clear on the next edge.
    do_op(STORE, 16'h0003, 16'h5555, 16'h0, 1, 2'd3, 16'h0012, 16'h03FE, 16'hC3D4, 1);
    @(posedge clock);
    #1;
    fault_clear = 1'b1;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    fault_clear = 1'b0;
    @(negedge clock);
    check("clear_after_misaligned", {30'd0, fault_code}, 32'h0);
    check("misaligned_no_write", {16'd0, dut.u_ram.mem[10'h001]}, 32'd100);
    wait_done();

    // op_valid held high: accepts only every third edge.
    op       = NOP;
    op_valid = 1'b1;
    pat      = '0;
    for (int k = 0; k < 9; k++) begin
      pat[k] = op_ready;
      @(posedge clock);
      #1;
      if (k % 3 == 0) begin
        e = '{data: 16'h0, fault: 1'b0, code: 2'd0, pc: 16'h0012, sp: 16'h03FE,
              inst: 16'hC3D4, acc: cyc};
        exp_q.push_back(EXP_W'(e));
      end
      @(negedge clock);
    end
    op_valid = 1'b0;
    check("cont_ready_pattern", {23'd0, pat}, 32'h049);
    wait_done();

    // Reset asserted at the MEM edge of a store.
    do_op(STORE, 16'h0004, 16'h1111, 16'h0, 0, 2'd0, 16'h0012, 16'h03FE, 16'hC3D4, 1);
    wait_done();
    do_op(STORE, 16'h0004, 16'h7777, 16'h0, 0, 2'd0, 16'h0, 16'h0, 16'h0, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("midrst_mem",   {16'd0, dut.u_ram.mem[10'h002]}, 32'h1111);
    check("midrst_pc",    {16'd0, pc_out},     32'h000C);
    check("midrst_sp",    {16'd0, sp_out},     32'h0200);
    check("midrst_inst",  {16'd0, inst_out},   32'h0);
    check("midrst_ready", {31'd0, op_ready},   32'h1);
    check("midrst_valid", {31'd0, rsp_valid},  32'h0);
    repeat (4) @(negedge clock);
    check("midrst_no_rsp", {31'd0, rsp_valid}, 32'h0);

    repeat (3) @(negedge clock);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pcsp_stack_unit.md
# pcsp_stack_unit

Parametrised successor to the datapath's PC/SP/memory block. Holds the program counter, the stack pointer, the instruction register and a unified word memory. It executes one sequenced memory operation at a time behind a valid/ready handshake. Supported operations are fetch, load, store, push, pop, call and return, with bounds-checked stack and alignment faults. It sits between the control unit and the register file/ALU result buses.

## Interface
- DATA_W, 16, data and instruction width
- ADDR_W, 16, byte-address width; the word step is 2
- MEM_WORDS, 1024, memory depth in words (power of two)
- PC_RESET, 0, PC value after reset
- STACK_BASE, 16'h0200, empty-stack SP value; the stack grows upward
- STACK_LIMIT, 16'h03FE, full-stack SP value; no push is allowed at this value

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low
- op_valid  in  1  an operation is presented
- op_ready  out  1  the block can accept an operation
- op  in  3  NOP=0, FETCH=1, LOAD=2, STORE=3, PUSH=4, POP=5, CALL=6, RET=7
- op_addr  in  ADDR_W  address for LOAD/STORE; target for CALL
- op_wdata  in  DATA_W  data for STORE/PUSH
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  DATA_W  read data (LOAD/POP/FETCH/RET), otherwise 0
- rsp_fault  out  1  the completing operation faulted
- fault_code  out  2  sticky fault: 0 none, 1 overflow, 2 underflow, 3 misaligned
- fault_clear  in  1  clears fault_code; ignored in the cycle a new fault is set
- inst_out  out  DATA_W  instruction register
- pc_out  out  ADDR_W  program counter
- sp_out  out  ADDR_W  stack pointer

## Operation
- The state machine has three states: IDLE, MEM, DONE. op_ready = (state==IDLE). An op is accepted on a rising edge with op_valid && op_ready. IDLE→MEM on accept. MEM→DONE always. DONE→IDLE always.
- On accept, the block latches op, op_addr, op_wdata and computes the effective address:
  - FETCH: PC
  - LOAD/STORE: op_addr
  - PUSH/CALL: SP
  - POP/RET: SP−2
- Fault checks are made at accept:
  - PUSH/CALL with SP==STACK_LIMIT → overflow.
  - POP/RET with SP==STACK_BASE → underflow.
  - LOAD/STORE with op_addr[0]==1 → misaligned.
- A faulted op does no memory write and changes no PC, SP or IR. It still completes with rsp_fault=1 and rsp_data=0.
- MEM edge:
  - The memory write commits: STORE/PUSH write op_wdata; CALL writes PC+2.
  - The synchronous read captures mem[word index].
  - The word index is addr[log2(MEM_WORDS):1]; upper bits are ignored, so the address wraps.
- DONE edge (architectural commit):
  - FETCH: IR ← data, PC ← PC+2
  - PUSH: SP ← SP+2
  - POP: SP ← SP−2
  - CALL: PC ← op_addr, SP ← SP+2
  - RET: PC ← data, SP ← SP−2
- PC arithmetic wraps modulo 2^ADDR_W.
- rsp_valid and rsp_data are driven in DONE. rsp_data is registered read data.
- NOP completes through the same path with no side effects.
- fault_code:
  - Set at the DONE edge of a faulted op.
  - When a new fault arrives while one is already held, the newest fault is kept.
  - fault_clear clears it otherwise.

## Timing
- Latency: accept at edge N. rsp_valid is high for the cycle between edges N+2 and N+3. The next accept is possible at edge N+3. Throughput is one op per 3 cycles.
- op_valid is ignored outside IDLE. Inputs need only be stable at the accept edge.
- Reset (reset==0 at a rising edge) gives:
  - state=IDLE, pc_out=PC_RESET, sp_out=STACK_BASE, inst_out=0
  - rsp_valid=0, rsp_data=0, rsp_fault=0, fault_code=0, op_ready=1 after the edge
- Memory contents are not reset.
- Reset mid-op: the op is abandoned. The memory write is suppressed if reset is asserted at the MEM edge. No commit happens.
- Every output is registered except op_ready, which decodes state.

## Structure
- Package pcsp_pkg holds the op encodings, the fault-code constants and the state enum.
- One sub-module, pcsp_ram: synchronous single-port RAM with MEM_WORDS×DATA_W storage, a write enable, and registered read-old-data.
- The FSM, pointer registers and fault logic live in pcsp_stack_unit.

## Test plan
- Reset, then STORE op_addr=2, op_wdata=100, then LOAD op_addr=2 → rsp_data=100, sp_out=STACK_BASE, and rsp_valid exactly 2 cycles after each accept.
- PUSH 0x1234, PUSH 0x5678, POP, POP → rsp_data 0x5678 then 0x1234. sp_out goes 0x0202, 0x0204, 0x0202, 0x0200.
- PC=0x0010 after two FETCHes of preloaded words, then CALL op_addr=0x0100 → pc_out=0x0100, mem[STACK_BASE]=0x0012. RET → pc_out=0x0012, sp_out=STACK_BASE.
- POP at SP=STACK_BASE → rsp_fault=1, fault_code=2, SP unchanged. Fill to STACK_LIMIT, then PUSH → fault_code=1, no write. Then fault_clear → fault_code=0.
- STORE op_addr=0x0003 → fault_code=3 and memory unchanged. op_valid held high continuously → accepts occur every 3rd edge only.
- reset=0 during MEM of STORE op_addr=4 → mem[2] unchanged. Registers take their reset values and op_ready=1 on the next cycle.
